ppwm_capture: RTL and testbench

//  Receive-side counterpart of the PPWM generator: measures an incoming PWM waveform.

---
 rtl/ppwm_pkg.sv | 12 +
 rtl/ppwm_sync_edge.sv | 32 +++
 rtl/ppwm_capture.sv | 139 +++++++++++++
 tb/tb_ppwm_capture.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppwm_pkg.sv
// Shared types and defaults for the PPWM generator/capture pair.
package ppwm_pkg;

   localparam int unsigned CAP_CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      CAP_IDLE,
      CAP_HIGH,
      CAP_LOW
   } cap_state_t;

endpackage

// File: rtl/ppwm_sync_edge.sv
// Synchronizes an asynchronous level and flags its rising/falling edges,
// one delay flop behind the synchronizer output.
module ppwm_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_din,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;
   logic                   w_level;

   assign w_level = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
         r_dly  <= w_level;
      end
   end

   assign o_rise = w_level & ~r_dly;
   assign o_fall = ~w_level & r_dly;

endmodule

// File: rtl/ppwm_capture.sv
// Measures high time and period of an incoming PWM signal in clock cycles and
// publishes each completed pair through a valid/ready result port.
module ppwm_capture
   import ppwm_pkg::*;
#(
   parameter int unsigned CNT_W       = CAP_CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_pwm_in,
   input  logic             i_res_ready,
   input  logic             i_clr_flags,
   output logic             o_res_valid,
   output logic [CNT_W-1:0] o_res_high,
   output logic [CNT_W-1:0] o_res_period,
   output logic             o_overrun,
   output logic             o_timeout,
   output logic             o_busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   cap_state_t       r_state;
   logic [CNT_W-1:0] r_cnt_high;
   logic [CNT_W-1:0] r_cnt_per;
   logic [CNT_W-1:0] r_res_high;
   logic [CNT_W-1:0] r_res_period;
   logic             r_res_valid;
   logic             r_overrun;
   logic             r_timeout;

   logic w_rise;
   logic w_fall;
   logic w_sat;
   logic w_pub;
   logic w_tmo;
   logic w_pop;

   ppwm_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_din (i_pwm_in),
      .o_rise(w_rise),
      .o_fall(w_fall)
   );

   // Saturation wins over edges so the counters can never wrap.
   always_comb begin
      w_sat = (r_cnt_per == CNT_MAX);
      w_tmo = i_en && (r_state != CAP_IDLE) && w_sat;
      w_pub = i_en && (r_state == CAP_LOW) && !w_sat && w_rise;
      w_pop = r_res_valid && i_res_ready;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= CAP_IDLE;
         r_cnt_high   <= '0;
         r_cnt_per    <= '0;
         r_res_high   <= '0;
         r_res_period <= '0;
         r_res_valid  <= 1'b0;
         r_overrun    <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         if (!i_en) begin
            r_state    <= CAP_IDLE;
            r_cnt_high <= '0;
            r_cnt_per  <= '0;
         end else begin
            case (r_state)
               CAP_IDLE: begin
                  if (w_rise) begin
                     r_state    <= CAP_HIGH;
                     r_cnt_high <= CNT_ONE;
                     r_cnt_per  <= CNT_ONE;
                  end
               end
               CAP_HIGH: begin
                  if (w_sat) begin
                     r_state    <= CAP_IDLE;
                     r_cnt_high <= '0;
                     r_cnt_per  <= '0;
                  end else if (w_fall) begin
                     r_state   <= CAP_LOW;
                     r_cnt_per <= r_cnt_per + 1'b1;
                  end else begin
                     r_cnt_high <= r_cnt_high + 1'b1;
                     r_cnt_per  <= r_cnt_per + 1'b1;
                  end
               end
               CAP_LOW: begin
                  if (w_sat) begin
                     r_state    <= CAP_IDLE;
                     r_cnt_high <= '0;
                     r_cnt_per  <= '0;
                  end else if (w_rise) begin
                     r_state    <= CAP_HIGH;
                     r_cnt_high <= CNT_ONE;
                     r_cnt_per  <= CNT_ONE;
                  end else begin
                     r_cnt_per <= r_cnt_per + 1'b1;
                  end
               end
               default: begin
                  r_state    <= CAP_IDLE;
                  r_cnt_high <= '0;
                  r_cnt_per  <= '0;
               end
            endcase
         end

         if (w_pub) begin
            r_res_high   <= r_cnt_high;
            r_res_period <= r_cnt_per;
            r_res_valid  <= 1'b1;
         end else if (w_pop) begin
            r_res_valid <= 1'b0;
         end

         // A same-cycle set beats the clear.
         r_overrun <= (w_pub && r_res_valid && !w_pop) || (r_overrun && !i_clr_flags);
         r_timeout <= w_tmo || (r_timeout && !i_clr_flags);
      end
   end

   assign o_res_valid  = r_res_valid;
   assign o_res_high   = r_res_high;
   assign o_res_period = r_res_period;
   assign o_overrun    = r_overrun;
   assign o_timeout    = r_timeout;
   assign o_busy       = (r_state != CAP_IDLE);

endmodule

// File: tb/tb_ppwm_capture.sv
// Bench for ppwm_capture: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized PWM traffic.
module tb_ppwm_capture;

   localparam int unsigned W    = 8;
   localparam int          S    = 2;
   localparam int          MAXC = (1 << W) - 1;

   logic         i_clk;
   logic         i_rst;
   logic         i_en;
   logic         i_pwm_in;
   logic         i_res_ready;
   logic         i_clr_flags;
   logic         o_res_valid;
   logic [W-1:0] o_res_high;
   logic [W-1:0] o_res_period;
   logic         o_overrun;
   logic         o_timeout;
   logic         o_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   ppwm_capture #(
      .CNT_W      (W),
      .SYNC_STAGES(S)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
      .i_pwm_in    (i_pwm_in),
      .i_res_ready (i_res_ready),
      .i_clr_flags (i_clr_flags),
      .o_res_valid (o_res_valid),
      .o_res_high  (o_res_high),
      .o_res_period(o_res_period),
      .o_overrun   (o_overrun),
      .o_timeout   (o_timeout),
      .o_busy      (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the FSM sees the pin delayed by S samples; a measurement is described
   // by the timestamps of its rising and falling edges rather than by counters.
   bit hist [0:S];
   int e        = 0;
   bit m_meas   = 0;
   int rise_at  = 0;
   int fall_at  = 0;
   bit m_valid  = 0;
   int m_high   = 0;
   int m_per    = 0;
   bit m_ovr    = 0;
   bit m_tmo    = 0;
   bit m_rise, m_fall, pub, tset, pop;
   int el;

   initial for (int i = 0; i <= S; i++) hist[i] = 1'b0;

   always @(posedge i_clk) begin
      m_rise = hist[S-1] && !hist[S];
      m_fall = !hist[S-1] && hist[S];
      if (i_rst) begin
         m_meas = 0; m_valid = 0; m_high = 0; m_per = 0; m_ovr = 0; m_tmo = 0;
         for (int i = 0; i <= S; i++) hist[i] = 1'b0;
      end else begin
         pub  = 0;
         tset = 0;
         pop  = m_valid && i_res_ready;
         if (!i_en) begin
            m_meas = 0;
         end else if (!m_meas) begin
            if (m_rise) begin
               m_meas  = 1;
               rise_at = e;
               fall_at = e;
            end
         end else begin
            el = e - rise_at;
            if (el == MAXC) begin
               tset   = 1;
               m_meas = 0;
            end else if (m_rise) begin
               pub     = 1;
               m_high  = fall_at - rise_at;
               m_per   = el;
               rise_at = e;
            end else if (m_fall) begin
               fall_at = e;
            end
         end
         m_ovr = (pub && m_valid && !pop) || (m_ovr && !i_clr_flags);
         m_tmo = tset || (m_tmo && !i_clr_flags);
         if (pub) m_valid = 1;
         else if (pop) m_valid = 0;
         for (int i = S; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = i_pwm_in;
      end
      e++;
      #1;
      if (m_valid) begin
         chk("cyc_valid", o_res_valid, m_valid);
      end else begin
         chk("cyc_valid", o_res_valid, 0);
      end
      chk("cyc_high", o_res_high, m_high);
      chk("cyc_period", o_res_period, m_per);
      chk("cyc_overrun", o_overrun, m_ovr);
      chk("cyc_timeout", o_timeout, m_tmo);
      chk("cyc_busy", o_busy, m_meas);
   end

   task automatic seg(input int h, input int l);
      i_pwm_in = 1'b1;
      repeat (h) @(negedge i_clk);
      i_pwm_in = 1'b0;
      repeat (l) @(negedge i_clk);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic pulse_clr();
      i_clr_flags = 1'b1;
      @(negedge i_clk);
      i_clr_flags = 1'b0;
   endtask

   initial begin
      int h, l;
      i_rst = 1'b1; i_en = 1'b0; i_pwm_in = 1'b0; i_res_ready = 1'b0; i_clr_flags = 1'b0;
      wait_n(3);
      i_rst = 1'b0;
      chk("rst_valid", o_res_valid, 0);
      chk("rst_period", o_res_period, 0);
      chk("rst_flags", {o_overrun, o_timeout, o_busy}, 0);

      // 3 high / 5 low
      i_en = 1'b1; i_res_ready = 1'b1;
      repeat (4) seg(3, 5);
      chk("p35_high", o_res_high, 3);
      chk("p35_period", o_res_period, 8);
      chk("p35_model", m_high * 100 + m_per, 308);

      // 50% duty, period 2
      repeat (6) seg(1, 1);
      chk("p11_high", o_res_high, 1);
      chk("p11_period", o_res_period, 2);
      chk("p11_overrun", o_overrun, 0);

      // Unread results get overwritten
      i_en = 1'b0; wait_n(5);
      pulse_clr();
      i_en = 1'b1; i_res_ready = 1'b0;
      repeat (3) seg(2, 6);
      i_pwm_in = 1'b1; wait_n(5);
      chk("ovr_valid", o_res_valid, 1);
      chk("ovr_flag", o_overrun, 1);
      chk("ovr_data", {o_res_high, o_res_period}, {8'd2, 8'd8});
      i_res_ready = 1'b1; wait_n(1);
      i_res_ready = 1'b0;
      chk("pop_valid", o_res_valid, 0);
      chk("pop_data", o_res_period, 8);

      // Stuck-high input saturates the period counter
      i_en = 1'b0; i_pwm_in = 1'b0; wait_n(5);
      pulse_clr();
      i_en = 1'b1; i_res_ready = 1'b1; wait_n(5);
      i_pwm_in = 1'b1; wait_n(300);
      chk("tmo_flag", o_timeout, 1);
      chk("tmo_busy", o_busy, 0);
      chk("tmo_valid", o_res_valid, 0);
      pulse_clr();
      chk("tmo_clr", o_timeout, 0);

      // en dropped in the low phase, then resumed
      i_pwm_in = 1'b0; wait_n(4);
      repeat (3) seg(4, 4);
      i_pwm_in = 1'b1; wait_n(4);
      i_pwm_in = 1'b0; wait_n(2);
      i_en = 1'b0; wait_n(2);
      i_en = 1'b1; wait_n(2);
      repeat (3) seg(4, 4);
      chk("en_high", o_res_high, 4);
      chk("en_period", o_res_period, 8);

      // Reset in the middle of a high phase
      i_pwm_in = 1'b1; wait_n(5);
      chk("mid_busy", o_busy, 1);
      i_rst = 1'b1;
      @(posedge i_clk); #2;
      chk("mrst_data", {o_res_high, o_res_period}, 0);
      chk("mrst_flags", {o_res_valid, o_overrun, o_timeout, o_busy}, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      i_pwm_in = 1'b0; wait_n(3);

      // Randomized traffic, with occasional reset, clear and enable drops
      for (int k = 0; k < 400; k++) begin
         h = int'($urandom_range(1, 5));
         l = int'($urandom_range(1, 6));
         i_res_ready = 1'($urandom_range(0, 1));
         i_en        = ($urandom_range(0, 29) != 0);
         i_clr_flags = ($urandom_range(0, 15) == 0);
         i_rst       = ($urandom_range(0, 99) == 0);
         i_pwm_in    = 1'b1;
         @(negedge i_clk);
         i_clr_flags = 1'b0;
         i_rst       = 1'b0;
         i_res_ready = 1'($urandom_range(0, 1));
         if (h > 1) wait_n(h - 1);
         i_pwm_in = 1'b0;
         wait_n(l);
      end

      wait_n(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
